uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver for 8N1 serial frames: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity. It oversamples the asynchronous RX line with the system clock and samples each bit at its centre. When a frame completes with a valid stop bit, it presents the received byte and a one-cycle done strobe. It sits between the board RX pin and the byte-level command/data logic.

Parameters:
- CLKS_PER_BIT, default 868, system clocks per serial bit (100 MHz / 115200 baud). Legal range is 4 or more. The implementation must enforce this with an elaboration-time check.

Ports:
- Clock, input, 1, system clock; all logic on the rising edge.
- Reset_n, input, 1, synchronous active-low reset.
- RX_Serial, input, 1, asynchronous serial line; idles high.
- RX_Done, output, 1, one-cycle strobe: a valid byte was received.
- RX_Bytes, output, 8, last valid received byte; held until the next valid frame.

Behaviour:
- Reset (Reset_n low at a clock edge): state=IDLE, counters=0, RX_Done=0, RX_Bytes=8'h00, synchronizer flops=1. Reset mid-frame abandons the frame; no RX_Done is produced for it.
- Input conditioning: RX_Serial passes through a 2-flop synchronizer (reset value 1). All sampling uses the synchronized bit rx_s. This adds 2 cycles of latency.
- Counter: clk_cnt has width $clog2(CLKS_PER_BIT). bit_idx is 3 bits.
- IDLE: clk_cnt=0, bit_idx=0. rx_s==0 moves to START.
- START: count to (CLKS_PER_BIT-1)/2 (integer division) to reach the bit centre.
  - rx_s==0 there: clk_cnt=0, go to DATA.
  - rx_s==1 there: false start; return to IDLE with no output.
- DATA: count CLKS_PER_BIT-1 cycles. On the next cycle, shift rx_s into the shift register at position bit_idx (LSB first) and clear clk_cnt.
  - After bit_idx==7: go to STOP.
  - Otherwise: bit_idx+1.
- STOP: count CLKS_PER_BIT-1 cycles to the stop-bit centre, then sample rx_s.
  - rx_s==1: RX_Bytes <= shift register and RX_Done <= 1 for exactly one cycle.
  - rx_s==0 (framing error): RX_Bytes unchanged, RX_Done stays 0.
  - Either way, go to CLEANUP.
- CLEANUP: one cycle; RX_Done returns to 0. Go to IDLE.
- Re-arm timing: IDLE is re-entered about 0.5 bit before the stop bit ends. A back-to-back start bit is therefore detected correctly.
- A line held low after a framing error restarts reception immediately. This is accepted behaviour.
- Latency: from the falling edge of the start bit at the pin to RX_Done high ≈ 2 + (CLKS_PER_BIT-1)/2 + 9·CLKS_PER_BIT + 2 cycles. This is always before the end of the stop bit.
- RX_Bytes is registered and never changes except in the RX_Done cycle, or to 0 on reset.
- RX_Done is never asserted in two consecutive cycles.

Decomposition:
- Shared package uart_pkg:
  - state enum {IDLE, START, DATA, STOP, CLEANUP}
  - UART_DATA_BITS = 8
  - default CLKS_PER_BIT = 868, shared with the UART TX.
- One optional sub-module: sync_2ff, a generic 2-flop synchronizer with a reset value parameter, reused by other CDC inputs. Everything else stays in uart_rx.

Test Plan:
- Send 0x37 at CLKS_PER_BIT=868 (bit period 8680 ns at 100 MHz) -> exactly one RX_Done pulse before the stop bit ends; RX_Bytes==8'h37 at and after the pulse.
- Back-to-back frames 0x00, 0xFF, 0xA5 with no idle gap -> three RX_Done pulses in order; RX_Bytes==0x00, 0xFF, 0xA5 respectively.
- Glitch: RX_Serial low for CLKS_PER_BIT/4 cycles, then high -> no RX_Done; RX_Bytes unchanged; the next valid 0x5A frame is received correctly.
- Framing error: frame 0xC3 with stop bit=0 -> no RX_Done; RX_Bytes keeps its prior value. After the line returns high, frame 0x3C -> RX_Done, RX_Bytes==0x3C.
- Reset_n low for 3 cycles during data bit 4 of 0x96 -> RX_Done=0, RX_Bytes=0x00. Partial frame ignored; the following frame 0x69 -> RX_Bytes==0x69.
- CLKS_PER_BIT=4, send 0x81 and 0x7E -> correct bytes and single-cycle RX_Done pulses. This checks the minimum-divisor corner.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, default bit divisor and receiver FSM encoding.
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 868;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] START   = 3'd1;
  localparam logic [2:0] DATA    = 3'd2;
  localparam logic [2:0] STOP    = 3'd3;
  localparam logic [2:0] CLEANUP = 3'd4;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for bringing asynchronous inputs into the clk_i domain.
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so both flops sample the pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversamples the synchronized RX line, samples each bit at its centre,
// and strobes RX_Done for one cycle when a frame ends with a valid stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                      Clock,
  input  logic                      Reset_n,
  input  logic                      RX_Serial,
  output logic                      RX_Done,
  output logic [UART_DATA_BITS-1:0] RX_Bytes
);

  localparam int                 CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]   CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam int                 IDX_W    = $clog2(UART_DATA_BITS);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(UART_DATA_BITS - 1);
  localparam logic [IDX_W-1:0]   IDX_ONE  = IDX_W'(1);

  if (CLKS_PER_BIT < 4) begin : g_bad_divisor
    $error("uart_rx: CLKS_PER_BIT must be 4 or more");
  end

  logic                      rx_s;
  logic [2:0]                state_q,   state_d;
  logic [CNT_W-1:0]          clk_cnt_q, clk_cnt_d;
  logic [IDX_W-1:0]          bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q,   shift_d;
  logic [UART_DATA_BITS-1:0] bytes_q,   bytes_d;
  logic                      done_q,    done_d;

  // The line idles high, so the synchronizer resets to 1 to avoid a spurious start bit.
  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk_i  (Clock),
    .rst_ni (Reset_n),
    .d_i    (RX_Serial),
    .q_o    (rx_s)
  );

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path through the case infers a latch.
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    bytes_d   = bytes_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        bit_idx_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (clk_cnt_q == CNT_HALF) begin
          clk_cnt_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      DATA: begin
        if (clk_cnt_q != CNT_LAST) begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end else begin
          clk_cnt_d          = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == IDX_LAST) begin
            bit_idx_d = '0;
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx_q + IDX_ONE;
          end
        end
      end
      STOP: begin
        if (clk_cnt_q != CNT_LAST) begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end else begin
          clk_cnt_d = '0;
          // A low stop bit is a framing error: the byte is dropped silently.
          if (rx_s) begin
            bytes_d = shift_q;
            done_d  = 1'b1;
          end
          state_d = CLEANUP;
        end
      end
      CLEANUP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the shift register is plain flops, so it is reset along with the rest of the state.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      bytes_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      bytes_q   <= bytes_d;
      done_q    <= done_d;
    end
  end

  assign RX_Done  = done_q;
  assign RX_Bytes = bytes_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: three receivers at divisors 868, 16 and 4 share clock and reset.
module tb_uart_rx;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] rx    = 3'b111;
  logic [2:0] done;
  logic [7:0] bytes [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(868)) dut_a (
    .Clock(clk), .Reset_n(rst_n), .RX_Serial(rx[0]), .RX_Done(done[0]), .RX_Bytes(bytes[0])
  );
  uart_rx #(.CLKS_PER_BIT(16)) dut_b (
    .Clock(clk), .Reset_n(rst_n), .RX_Serial(rx[1]), .RX_Done(done[1]), .RX_Bytes(bytes[1])
  );
  uart_rx #(.CLKS_PER_BIT(4)) dut_c (
    .Clock(clk), .Reset_n(rst_n), .RX_Serial(rx[2]), .RX_Done(done[2]), .RX_Bytes(bytes[2])
  );

  // Pulse monitor: counts done pulses, captures the byte at each pulse, and flags
  // back-to-back done cycles or RX_Bytes changing outside a done cycle or reset.
  int         pulses [3] = '{0, 0, 0};
  int         viol   [3] = '{0, 0, 0};
  logic [7:0] cap    [3][8];
  logic [7:0] prev_bytes [3];
  logic [2:0] prev_done;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done[i] === 1'b1) begin
        if (pulses[i] < 8) cap[i][pulses[i]] = bytes[i];
        pulses[i]++;
        if (prev_done[i] === 1'b1) viol[i]++;
      end else if (rst_n && prev_done[i] !== 1'bx && bytes[i] !== prev_bytes[i]) begin
        viol[i]++;
      end
      prev_done[i]  = done[i];
      prev_bytes[i] = bytes[i];
    end
  end

  function automatic int cpb(input int i);
    return (i == 0) ? 868 : (i == 1) ? 16 : 4;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx[i] = f[k];
      idle(cpb(i));
    end
  endtask

  initial begin
    int         base;
    logic [9:0] f;

    // Reset state
    idle(3);
    check("rst_done_a", 32'(done[0]), 32'h0);
    check("rst_bytes_a", 32'(bytes[0]), 32'h00);
    check("rst_bytes_c", 32'(bytes[2]), 32'h00);
    rst_n = 1'b1;
    idle(5);

    // Single frame 0x37 at 868: pulse lands before the stop bit ends
    base = pulses[0];
    send(0, 8'h37, 1'b1);
    check("a37_pulse_by_stop_end", 32'(pulses[0]), 32'(base + 1));
    check("a37_cap", 32'(cap[0][base]), 32'h37);
    idle(50);
    check("a37_single_pulse", 32'(pulses[0]), 32'(base + 1));
    check("a37_held", 32'(bytes[0]), 32'h37);

    // Back-to-back 0x00, 0xFF, 0xA5 with no idle gap
    base = pulses[0];
    send(0, 8'h00, 1'b1);
    send(0, 8'hFF, 1'b1);
    send(0, 8'hA5, 1'b1);
    idle(20);
    check("b2b_pulses", 32'(pulses[0]), 32'(base + 3));
    check("b2b_cap0", 32'(cap[0][base]), 32'h00);
    check("b2b_cap1", 32'(cap[0][base + 1]), 32'hFF);
    check("b2b_cap2", 32'(cap[0][base + 2]), 32'hA5);
    check("b2b_held", 32'(bytes[0]), 32'hA5);

    // Divisor 16: prime a known byte, then a short glitch
    base = pulses[1];
    send(1, 8'hE7, 1'b1);
    idle(4);
    check("bE7_pulse", 32'(pulses[1]), 32'(base + 1));
    check("bE7_bytes", 32'(bytes[1]), 32'hE7);
    rx[1] = 1'b0;
    idle(16 / 4);
    rx[1] = 1'b1;
    idle(48);
    check("glitch_no_pulse", 32'(pulses[1]), 32'(base + 1));
    check("glitch_bytes_kept", 32'(bytes[1]), 32'hE7);
    send(1, 8'h5A, 1'b1);
    idle(4);
    check("b5A_pulse", 32'(pulses[1]), 32'(base + 2));
    check("b5A_cap", 32'(cap[1][base + 1]), 32'h5A);
    check("b5A_bytes", 32'(bytes[1]), 32'h5A);

    // Framing error: 0xC3 with a low stop bit, then 0x3C
    send(1, 8'hC3, 1'b0);
    rx[1] = 1'b1;
    idle(48);
    check("ferr_no_pulse", 32'(pulses[1]), 32'(base + 2));
    check("ferr_bytes_kept", 32'(bytes[1]), 32'h5A);
    send(1, 8'h3C, 1'b1);
    idle(4);
    check("b3C_pulse", 32'(pulses[1]), 32'(base + 3));
    check("b3C_cap", 32'(cap[1][base + 2]), 32'h3C);
    check("b3C_bytes", 32'(bytes[1]), 32'h3C);

    // Reset for 3 cycles in the middle of data bit 4 of 0x96
    f = {1'b1, 8'h96, 1'b0};
    for (int k = 0; k < 5; k++) begin
      rx[1] = f[k];
      idle(16);
    end
    rx[1] = f[5];
    idle(8);
    rst_n = 1'b0;
    idle(3);
    check("midrst_done", 32'(done[1]), 32'h0);
    check("midrst_bytes", 32'(bytes[1]), 32'h00);
    rst_n = 1'b1;
    rx[1] = 1'b1;
    idle(200);
    check("midrst_no_pulse", 32'(pulses[1]), 32'(base + 3));
    send(1, 8'h69, 1'b1);
    idle(4);
    check("b69_pulse", 32'(pulses[1]), 32'(base + 4));
    check("b69_bytes", 32'(bytes[1]), 32'h69);

    // Minimum divisor: back-to-back 0x81 and 0x7E
    base = pulses[2];
    send(2, 8'h81, 1'b1);
    send(2, 8'h7E, 1'b1);
    idle(8);
    check("c_pulses", 32'(pulses[2]), 32'(base + 2));
    check("c_cap81", 32'(cap[2][base]), 32'h81);
    check("c_cap7E", 32'(cap[2][base + 1]), 32'h7E);
    check("c_bytes", 32'(bytes[2]), 32'h7E);

    // Done never in two consecutive cycles; RX_Bytes only moves on done or reset
    check("viol_a", 32'(viol[0]), 32'h0);
    check("viol_b", 32'(viol[1]), 32'h0);
    check("viol_c", 32'(viol[2]), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
